// File: rtl/mips_rf_pkg.sv
// Shared types, sizes and the write-port priority helper for the multi-port register file.
package mips_rf_pkg;

  localparam int unsigned RF_DW        = 32;
  localparam int unsigned RF_DEPTH     = 32;
  localparam int unsigned RF_AW        = 5;
  localparam int unsigned REG_ZERO     = 0;
  // Upper bound on write ports the priority helper can arbitrate between.
  localparam int unsigned RF_MAX_PORTS = 16;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  // Highest-index set bit wins (later-issued slot); -1 when nothing hits.
  function automatic int rf_highest(input logic [RF_MAX_PORTS-1:0] hits);
    int w;
    w = -1;
    for (int j = 0; j < int'(RF_MAX_PORTS); j++) begin
      if (hits[j]) w = j;
    end
    return w;
  endfunction

endpackage

// File: rtl/mp_register_file_if.sv
// Decode/writeback side bundle of the multi-port register file.
interface mp_register_file_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 4,
  parameter int unsigned NW = 2
);
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pend;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    iss_en;
  logic [NW*AW-1:0] iss_addr;
  logic             flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_pend
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_pend
  );
endinterface

// File: rtl/mp_register_file_rf_write_arbiter.sv
// Per-register write select: the highest-index enabled port targeting a register wins.
module rf_write_arbiter
  import mips_rf_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NW    = 2
) (
  input  logic [NW-1:0]       wr_en,
  input  logic [NW*AW-1:0]    wr_addr,
  input  logic [NW*DW-1:0]    wr_data,
  output logic [DEPTH-1:0]    reg_we,
  output logic [DEPTH*DW-1:0] reg_wdata
);

  logic [RF_MAX_PORTS-1:0] hit;
  int                      win;

  always_comb begin
    reg_we    = '0;
    reg_wdata = '0;
    hit       = '0;
    win       = -1;
    for (int r = 0; r < int'(DEPTH); r++) begin
      hit = '0;
      for (int j = 0; j < int'(NW); j++) begin
        hit[j] = wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r));
      end
      win = rf_highest(hit);
      if (r != int'(REG_ZERO) && win >= 0) begin
        reg_we[r] = 1'b1;
        for (int j = 0; j < int'(NW); j++) begin
          if (j == win) reg_wdata[r*DW +: DW] = wr_data[j*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/mp_register_file.sv
// Multi-port GPR file with optional writeback bypass and a pending-write scoreboard.
module mp_register_file
  import mips_rf_pkg::*;
#(
  parameter int unsigned DW     = RF_DW,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned NR     = 4,
  parameter int unsigned NW     = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic               clk,
  input logic               reset,
  mp_register_file_if.slave rf
);

  logic [DW-1:0]       regs_q [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [DEPTH-1:0]    reg_we;
  logic [DEPTH*DW-1:0] reg_wdata;

  rf_write_arbiter #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW),
    .NW   (NW)
  ) u_arb (
    .wr_en    (rf.wr_en),
    .wr_addr  (rf.wr_addr),
    .wr_data  (rf.wr_data),
    .reg_we   (reg_we),
    .reg_wdata(reg_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < int'(DEPTH); r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        if (reg_we[r]) regs_q[r] <= reg_wdata[r*DW +: DW];
      end
    end
  end

  // Flush beats a new issue, a new issue beats a writeback clear.
  logic ih, wh;
  always_comb begin
    pend_d = '0;
    ih     = 1'b0;
    wh     = 1'b0;
    for (int r = 1; r < int'(DEPTH); r++) begin
      ih = 1'b0;
      wh = 1'b0;
      for (int j = 0; j < int'(NW); j++) begin
        ih = ih | (rf.iss_en[j] && (rf.iss_addr[j*AW +: AW] == AW'(r)));
        wh = wh | (rf.wr_en[j] && (rf.wr_addr[j*AW +: AW] == AW'(r)));
      end
      if (rf.flush)  pend_d[r] = 1'b0;
      else if (ih)   pend_d[r] = 1'b1;
      else if (wh)   pend_d[r] = 1'b0;
      else           pend_d[r] = pend_q[r];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  logic [AW-1:0]           ra;
  logic [RF_MAX_PORTS-1:0] rhit;
  logic                    riss;
  int                      rw;
  logic [NR*DW-1:0]        rd_data;
  logic [NR-1:0]           rd_pend;

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    rhit    = '0;
    riss    = 1'b0;
    rw      = -1;
    for (int i = 0; i < int'(NR); i++) begin
      ra   = rf.rd_addr[i*AW +: AW];
      rhit = '0;
      riss = 1'b0;
      for (int j = 0; j < int'(NW); j++) begin
        rhit[j] = rf.wr_en[j] && (rf.wr_addr[j*AW +: AW] == ra);
        riss    = riss | (rf.iss_en[j] && (rf.iss_addr[j*AW +: AW] == ra));
      end
      rw = rf_highest(rhit);
      // Gating on reset keeps bypassed writeback data off the outputs during reset.
      if (reset && ra != AW'(REG_ZERO)) begin
        if (BYPASS != 0 && rw >= 0) begin
          for (int j = 0; j < int'(NW); j++) begin
            if (j == rw) rd_data[i*DW +: DW] = rf.wr_data[j*DW +: DW];
          end
          rd_pend[i] = riss & pend_q[ra];
        end else begin
          rd_data[i*DW +: DW] = regs_q[ra];
          rd_pend[i]          = pend_q[ra];
        end
      end
    end
  end

  assign rf.rd_data = rd_data;
  assign rf.rd_pend = rd_pend;

endmodule

// File: doc/mp_register_file.md
Name: mp_register_file

Overview:
- Parametrised multi-port general-purpose register file for the multi-issue MIPS pipeline. Generalises the dual-issue 2-write/4-read file.
- Adds configurable read/write port counts, data width and depth, and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard; decode uses it to detect RAW hazards on outstanding producers.
- Sits between decode (reads, issue marking) and writeback (writes, scoreboard clear).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(DEPTH), address width.
- NR, 4, number of read ports.
- NW, 2, number of write ports; also the number of issue-mark ports.
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to reads; 0 = reads see only stored values.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NR*AW  read addresses, port i in bits [i*AW +: AW].
- rd_data  out  NR*DW  read data, port i in bits [i*DW +: DW].
- rd_pend  out  NR  1 = the addressed register has an outstanding producer.
- wr_en  in  NW  writeback enables.
- wr_addr  in  NW*AW  writeback addresses.
- wr_data  in  NW*DW  writeback data.
- iss_en  in  NW  issue-mark enables: set pending on the destination register.
- iss_addr  in  NW*AW  issue destination addresses.
- flush  in  1  synchronous clear of all pending bits; stored data is untouched.

Behaviour:
- Reset:
  - Asserting reset (low) immediately clears all DEPTH registers to 0 and all pending bits to 0, independent of clk.
  - While reset is held, writes, issue marks and flush are ignored.
  - Reset may be asserted mid-operation; the state is lost with no partial update.
  - rd_data and rd_pend are combinational. With reset low they read 0 for every address.
- Register 0:
  - Reads always return 0 with rd_pend = 0.
  - Writes, issue marks and flush have no effect on register 0.
- Read path: combinational, zero latency.
  - With BYPASS=1, if any wr_en[j] is set with wr_addr[j] == rd_addr[i] != 0, rd_data[i] returns wr_data[j] in the same cycle.
  - If several ports match, the highest j wins.
  - Otherwise rd_data[i] returns the stored value.
- Write path, at the rising edge:
  - Each enabled port j with a nonzero address updates its register.
  - When several enabled ports target the same address, only the highest-index port writes, so program order is preserved with the later-issued slot at the higher index.
  - The lower-index ports targeting that address are dropped entirely, with no X and no double-drive.
- Scoreboard (pending[r]), updated at the rising edge in this priority order:
  1. flush = 1: all pending bits clear, even if iss_en is set in the same cycle.
  2. Otherwise, for each r != 0: if any iss_en[j] targets r, pending[r] becomes 1. A new producer wins over a simultaneous writeback clear.
  3. Otherwise, if any wr_en[j] targets r, pending[r] becomes 0.
  4. Otherwise pending[r] holds.
- rd_pend[i]:
  - rd_pend[i] = pending[rd_addr[i]].
  - With BYPASS=1, it is forced to 0 when a same-cycle writeback hit on that address supplies the data, unless iss_en targets that address in the same cycle.
  - With BYPASS=0, it reflects pending only.
- Boundary cases:
  - Address values >= DEPTH cannot occur when DEPTH = 2^AW.
  - wr_en without a prior issue mark is legal: the data is written and pending stays 0.
  - A duplicate issue to an already pending register keeps it pending.
- No clock gating, no initial blocks, no intra-assignment delays. All registered state uses a single always block per function with asynchronous active-low reset.

Decomposition:
- Shared package mips_rf_pkg:
  - RF_DW = 32, RF_DEPTH = 32, RF_AW = 5.
  - Constant REG_ZERO = 0.
  - typedef rf_addr_t = logic [RF_AW-1:0].
  - typedef rf_data_t = logic [DW-1:0].
- One sub-module, rf_write_arbiter: for each register, combinationally select the winning write port (highest index) and produce per-register write-enable and data.
  - Instantiated once.
  - Reused by the bypass logic through the same priority function defined in the package.
- Scoreboard logic is inline.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pull reset low between clock edges -> rd_data for r5 = 0 immediately and rd_pend = 0 for all ports. Release reset; r5 still reads 0.
- Zero register: wr_en[0] = 1, addr 0, data 0x12345678, plus iss_en on r0 -> next cycle r0 reads 0 and rd_pend = 0.
- Write conflict: port0 writes r7 = 0x11111111 and port1 writes r7 = 0x22222222 in the same cycle -> next cycle r7 = 0x22222222. In the same cycle with BYPASS=1, a read of r7 returns 0x22222222.
- Bypass: BYPASS=1, r9 stored value 0xA, wr_en[1] r9 = 0xB -> rd_data = 0xB in the same cycle. With BYPASS=0 the same stimulus gives 0xA, then 0xB after the edge.
- Scoreboard: issue r3 in cycle 0 -> rd_pend = 1 from cycle 1. Writeback r3 = 0x55 and issue r3 together in cycle 4 -> still pending in cycle 5. Writeback only in cycle 6 -> pending clears in cycle 7 and data = final value.
- Flush: pend r2, r4 and r6, then assert flush while iss_en targets r8 -> next cycle all pending bits 0 and stored data unchanged.
